// File: rtl/arm_mon_pkg.sv
// Shared types and default sizing for the ARM run monitor.
// Holds the controller state encoding and the default parameter values.
package arm_mon_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StHold,
    StRun,
    StCheck,
    StDone
  } mon_state_e;

  localparam int unsigned DefDataW      = 32;
  localparam int unsigned DefNumWatch   = 7;
  localparam int unsigned DefCntW       = 16;
  localparam int unsigned DefRstCycles  = 2;
  localparam int unsigned DefStallLimit = 8;
  localparam int unsigned DefTimeout    = 1000;

endpackage

// File: rtl/arm_run_monitor_if.sv
// Observation and result signals exchanged between the run monitor and its environment.
// The environment (CPU side and test harness) is master; the monitor is slave.
interface arm_run_monitor_if #(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned NUM_WATCH = 7,
  parameter int unsigned CNT_W     = 16
);
  logic                          start;
  logic [DATA_W-1:0]             pc_if;
  logic [DATA_W-1:0]             instruction_if;
  logic [NUM_WATCH*DATA_W-1:0]   watch_data;
  logic [NUM_WATCH*DATA_W-1:0]   expect_data;
  logic [NUM_WATCH-1:0]          expect_mask;
  logic                          cpu_rst;
  logic                          running;
  logic                          done;
  logic                          pass;
  logic                          timeout;
  logic [CNT_W-1:0]              cycle_count;
  logic [CNT_W-1:0]              instr_count;
  logic [NUM_WATCH-1:0]          mismatch_vec;

  modport master (
    output start, pc_if, instruction_if, watch_data, expect_data, expect_mask,
    input  cpu_rst, running, done, pass, timeout, cycle_count, instr_count, mismatch_vec
  );

  modport slave (
    input  start, pc_if, instruction_if, watch_data, expect_data, expect_mask,
    output cpu_rst, running, done, pass, timeout, cycle_count, instr_count, mismatch_vec
  );
endinterface

// File: rtl/arm_halt_detect.sv
// Detects a halted CPU: the fetch PC unchanged for STALL_LIMIT consecutive RUN cycles.
// halt_o is combinational so the controller can leave RUN on the same edge.
module arm_halt_detect #(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned STALL_LIMIT = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en_i,
  input  logic              first_i,
  input  logic [DATA_W-1:0] pc_i,
  output logic              halt_o
);
  localparam int unsigned SameW = $clog2(STALL_LIMIT + 1);

  logic [DATA_W-1:0] pc_prev_q;
  logic [SameW-1:0]  same_cnt_q, same_cnt_d;

  // pc_prev_q is meaningless on the first RUN cycle, so the count restarts there.
  always_comb begin
    same_cnt_d = same_cnt_q;
    if (en_i) begin
      if (first_i || (pc_i != pc_prev_q)) begin
        same_cnt_d = '0;
      end else begin
        same_cnt_d = same_cnt_q + 1'b1;
      end
    end
  end

  assign halt_o = en_i && (same_cnt_d == SameW'(STALL_LIMIT));

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_prev_q  <= '0;
      same_cnt_q <= '0;
    end else if (en_i) begin
      pc_prev_q  <= pc_i;
      same_cnt_q <= same_cnt_d;
    end
  end

endmodule

// File: rtl/arm_run_monitor.sv
// Run controller and result checker: holds the CPU in reset, runs it until halt or timeout,
// then compares watched memory words against expected values.
module arm_run_monitor
  import arm_mon_pkg::*;
#(
  parameter int unsigned DATA_W      = DefDataW,
  parameter int unsigned NUM_WATCH   = DefNumWatch,
  parameter int unsigned CNT_W       = DefCntW,
  parameter int unsigned RST_CYCLES  = DefRstCycles,
  parameter int unsigned STALL_LIMIT = DefStallLimit,
  parameter int unsigned TIMEOUT     = DefTimeout
) (
  input  logic               clk,
  input  logic               rst,
  arm_run_monitor_if.slave   bus
);
  localparam int unsigned HoldW = $clog2(RST_CYCLES + 1);

  mon_state_e           state_q;
  logic [HoldW-1:0]     hold_q;
  logic                 cpu_rst_q, running_q, done_q, pass_q, timeout_q;
  logic [CNT_W-1:0]     cycle_count_q, cycle_count_d;
  logic [CNT_W-1:0]     instr_count_q, instr_count_d;
  logic [NUM_WATCH-1:0] mismatch_q, mismatch_d;
  logic                 halt, run_tmo, in_run;

  assign in_run = (state_q == StRun);

  arm_halt_detect #(
    .DATA_W      (DATA_W),
    .STALL_LIMIT (STALL_LIMIT)
  ) u_halt_detect (
    .clk     (clk),
    .rst     (rst),
    .en_i    (in_run),
    .first_i (cycle_count_q == '0),
    .pc_i    (bus.pc_if),
    .halt_o  (halt)
  );

  assign cycle_count_d = cycle_count_q + 1'b1;
  assign run_tmo       = (cycle_count_d == CNT_W'(TIMEOUT));

  always_comb begin
    instr_count_d = instr_count_q;
    if ((bus.instruction_if != '0) && (instr_count_q != '1)) begin
      instr_count_d = instr_count_q + 1'b1;
    end
  end

  for (genvar g = 0; g < NUM_WATCH; g++) begin : g_cmp
    assign mismatch_d[g] = bus.expect_mask[g] &&
        (bus.watch_data[g*DATA_W +: DATA_W] != bus.expect_data[g*DATA_W +: DATA_W]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      hold_q        <= '0;
      cpu_rst_q     <= 1'b1;
      running_q     <= 1'b0;
      done_q        <= 1'b0;
      pass_q        <= 1'b0;
      timeout_q     <= 1'b0;
      cycle_count_q <= '0;
      instr_count_q <= '0;
      mismatch_q    <= '0;
    end else begin
      unique case (state_q)
        StIdle, StDone: begin
          if (bus.start) begin
            state_q       <= StHold;
            hold_q        <= HoldW'(RST_CYCLES);
            cpu_rst_q     <= 1'b1;
            running_q     <= 1'b0;
            done_q        <= 1'b0;
            pass_q        <= 1'b0;
            timeout_q     <= 1'b0;
            cycle_count_q <= '0;
            instr_count_q <= '0;
            mismatch_q    <= '0;
          end
        end
        StHold: begin
          if (hold_q == '0) begin
            state_q   <= StRun;
            cpu_rst_q <= 1'b0;
            running_q <= 1'b1;
          end else begin
            hold_q <= hold_q - 1'b1;
          end
        end
        StRun: begin
          cycle_count_q <= cycle_count_d;
          instr_count_q <= instr_count_d;
          // A halt detected on the timeout cycle still counts as a clean stop.
          if (halt || run_tmo) begin
            state_q   <= StCheck;
            running_q <= 1'b0;
            timeout_q <= run_tmo && !halt;
          end
        end
        StCheck: begin
          state_q    <= StDone;
          mismatch_q <= mismatch_d;
          pass_q     <= !timeout_q && (mismatch_d == '0);
          done_q     <= 1'b1;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.cpu_rst      = cpu_rst_q;
  assign bus.running      = running_q;
  assign bus.done         = done_q;
  assign bus.pass         = pass_q;
  assign bus.timeout      = timeout_q;
  assign bus.cycle_count  = cycle_count_q;
  assign bus.instr_count  = instr_count_q;
  assign bus.mismatch_vec = mismatch_q;

endmodule
